// File: rtl/load_pkg.sv
// Shared encodings for the load unit: access-size codes and the FSM state type.
package load_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } ld_state_e;

endpackage

// File: rtl/load_unit_if.sv
// Issue-side request, memory-bus read and writeback-response signals of the load unit.
interface load_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [TAG_W-1:0] req_tag;

  logic             bus_req;
  logic [XLEN-1:0]  bus_addr;
  logic             bus_gnt;
  logic             bus_rvalid;
  logic [XLEN-1:0]  bus_rdata;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_fault;
  logic             busy;

  // Environment side: issue stage, memory bus and writeback.
  modport master (
    output req_valid, req_addr, req_size, req_signed, req_tag,
    input  req_ready,
    input  bus_req, bus_addr,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  rsp_valid, rsp_data, rsp_tag, rsp_fault, busy,
    output rsp_ready
  );

  // Load unit side.
  modport slave (
    input  req_valid, req_addr, req_size, req_signed, req_tag,
    output req_ready,
    output bus_req, bus_addr,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output rsp_valid, rsp_data, rsp_tag, rsp_fault, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/load_fifo.sv
// In-order request queue; pushes while full are dropped, push and pop may coincide.
module load_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  // Extra pointer bit distinguishes a full ring from an empty one.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: queues load requests, issues one bus read at a time, returns lane-selected, extended data.
// Optional LOAD_UNIT_ALIGN_CHECK_EN: misaligned loads fault without touching the bus.
module load_unit
  import load_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  load_unit_if.slave lif
);
  localparam int OFF_W = $clog2(XLEN/8);

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [1:0]       size;
    logic             sgn;
    logic [TAG_W-1:0] tag;
  } ld_entry_t;

  localparam int ENT_W = $bits(ld_entry_t);

  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (XLEN == 32 && size == SZ_DWORD) ? SZ_WORD : size;
  endfunction

  function automatic logic [OFF_W-1:0] lane_off(input logic [OFF_W-1:0] off, input logic [1:0] size);
    logic [OFF_W-1:0] lo;
    lo = '0;
    case (size)
      SZ_BYTE: lo = off;
      SZ_HALF: lo = {off[OFF_W-1:1], 1'b0};
      SZ_WORD: if (XLEN == 64) lo[OFF_W-1] = off[OFF_W-1];
      default: lo = '0;
    endcase
    return lo;
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] beat, input logic [OFF_W-1:0] off,
                                             input logic [1:0] size, input logic sgn);
    logic        [XLEN-1:0] sh;
    logic        [XLEN-1:0] z_ext;
    logic signed [XLEN-1:0] s_ext;
    sh = beat >> {lane_off(off, size), 3'b000};
    case (size)
      SZ_BYTE: begin z_ext = XLEN'(sh[7:0]);  s_ext = XLEN'($signed(sh[7:0]));  end
      SZ_HALF: begin z_ext = XLEN'(sh[15:0]); s_ext = XLEN'($signed(sh[15:0])); end
      SZ_WORD: begin z_ext = XLEN'(sh[31:0]); s_ext = XLEN'($signed(sh[31:0])); end
      default: begin z_ext = sh;              s_ext = $signed(sh);              end
    endcase
    return sgn ? $unsigned(s_ext) : z_ext;
  endfunction

`ifdef LOAD_UNIT_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] size);
    case (size)
      SZ_HALF:  return a[0];
      SZ_WORD:  return a[1:0] != 2'b00;
      SZ_DWORD: return a != 3'b000;
      default:  return 1'b0;
    endcase
  endfunction
`endif

  ld_state_e        state_q, state_d;
  ld_entry_t        in_ent, head_ent, src_ent, act_q;
  logic [ENT_W-1:0] head_raw;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             accept, load_act, src_bad;
  logic [XLEN-1:0]  rsp_data_q;

  assign in_ent   = '{addr: lif.req_addr, size: eff_size(lif.req_size), sgn: lif.req_signed, tag: lif.req_tag};
  assign head_ent = ld_entry_t'(head_raw);
  assign accept   = lif.req_valid && !fifo_full;
  // An idle unit with an empty queue takes the incoming request straight into the active slot.
  assign fifo_push = accept && !(state_q == ST_IDLE && fifo_empty);
  assign src_ent   = fifo_empty ? in_ent : head_ent;

`ifdef LOAD_UNIT_ALIGN_CHECK_EN
  assign src_bad = misaligned(src_ent.addr[2:0], src_ent.size);
`else
  assign src_bad = 1'b0;
`endif

  load_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_ent),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load_act = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load_act = 1'b1;
        end else if (accept) begin
          load_act = 1'b1;
        end
      end
      ST_REQ:  if (lif.bus_gnt)    state_d = ST_WAIT;
      ST_WAIT: if (lif.bus_rvalid) state_d = ST_RESP;
      ST_RESP: begin
        if (lif.rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load_act = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_act) state_d = src_bad ? ST_RESP : ST_REQ;
  end

  // Active entry and result register; the beat is extended as it is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= '0;
      rsp_data_q <= '0;
    end else if (load_act) begin
      act_q <= src_ent;
      if (src_bad) rsp_data_q <= '0;
    end else if (state_q == ST_WAIT && lif.bus_rvalid) begin
      rsp_data_q <= extend(lif.bus_rdata, act_q.addr[OFF_W-1:0], act_q.size, act_q.sgn);
    end
  end

`ifdef LOAD_UNIT_ALIGN_CHECK_EN
  logic rsp_fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rsp_fault_q <= 1'b0;
    else if (load_act) rsp_fault_q <= src_bad;
  end
  assign lif.rsp_fault = rsp_fault_q;
`else
  assign lif.rsp_fault = 1'b0;
`endif

  assign lif.req_ready = !fifo_full;
  assign lif.bus_req   = (state_q == ST_REQ);
  assign lif.bus_addr  = {act_q.addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign lif.rsp_valid = (state_q == ST_RESP);
  assign lif.rsp_data  = rsp_data_q;
  assign lif.rsp_tag   = act_q.tag;
  assign lif.busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule
